// File: rtl/lfsr_num_gen.sv
// lfsr_num_gen: 8-bit LFSR / shift-register number source for the hex display.
// Steps on a debounced button press or an auto-run tick; parallel load wins.
module lfsr_num_gen #(
  parameter logic [7:0] SEED       = 8'h01,
  parameter int         DEBOUNCE_N = 16,
  parameter int         AUTO_DIV   = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       auto_en,
  input  logic       load,
  input  logic [7:0] din,
  input  logic [1:0] mode,
  output logic [7:0] q,
  output logic [3:0] num0,
  output logic [3:0] num1,
  output logic       tick
);

  localparam int CW = $clog2(DEBOUNCE_N);
  localparam int DW = $clog2(AUTO_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_N - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(AUTO_DIV - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic          stable_q;
  logic          stable_prev_q;
  logic [DW-1:0] div_q;
  logic [7:0]    q_q;
  logic [7:0]    q_d;
  logic          tick_q;
  logic          press;
  logic          auto_tick;
  logic          step;
  logic          fb;

  // two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // accept a new button level only after it holds for DEBOUNCE_N cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
    end else begin
      stable_prev_q <= stable_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press = stable_q & ~stable_prev_q;

  // auto-run divider, held at zero while auto-run is off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (!auto_en) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign auto_tick = auto_en & (div_q == DIV_LAST);
  assign step      = press | auto_tick;
  assign fb        = q_q[4] ^ q_q[3] ^ q_q[2] ^ q_q[0];

  // next value of the register for the selected step operation
  always_comb begin
    q_d = q_q;
    unique case (mode)
      2'b00: q_d = (q_q == 8'h00) ? SEED : {fb, q_q[7:1]};
      2'b01: q_d = {q_q[6:0], 1'b0};
      2'b10: q_d = {q_q[7], q_q[7:1]};
      2'b11: q_d = {q_q[0], q_q[7:1]};
    endcase
  end

  // main register: load beats step, tick marks a completed step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= SEED;
      tick_q <= 1'b0;
    end else if (load) begin
      q_q    <= din;
      tick_q <= 1'b0;
    end else if (step) begin
      q_q    <= q_d;
      tick_q <= 1'b1;
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign q    = q_q;
  assign num0 = q_q[3:0];
  assign num1 = q_q[7:4];
  assign tick = tick_q;

endmodule

// File: tb/tb_lfsr_num_gen.sv
// tb_lfsr_num_gen: scoreboard bench for lfsr_num_gen.
// Expected step results are queued; a monitor checks them on each tick.
module tb_lfsr_num_gen;

  localparam int DB = 16;
  localparam int AD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       auto_en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] din = 8'h00;
  logic [1:0] mode = 2'b00;
  logic [7:0] q;
  logic [3:0] num0;
  logic [3:0] num1;
  logic       tick;

  typedef struct {
    logic [7:0] v;
    bit         exact;
  } exp_t;

  exp_t sb[$];
  int   tick_cyc[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   tick_cnt = 0;

  lfsr_num_gen #(
    .SEED(8'h01),
    .DEBOUNCE_N(DB),
    .AUTO_DIV(AD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .auto_en(auto_en),
    .load(load),
    .din(din),
    .mode(mode),
    .q(q),
    .num0(num0),
    .num1(num1),
    .tick(tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every tick pops one expected result
  always @(negedge clk) begin
    exp_t e;
    if (!rst && tick) begin
      tick_cnt++;
      tick_cyc.push_back(cyc);
      tests++;
      if ({num1, num0} !== q) begin
        fails++;
        $display("FAIL nums: got %h want %h", {num1, num0}, q);
      end
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_tick: got q=%h at cyc %0d want no tick", q, cyc);
      end else begin
        e = sb.pop_front();
        if (e.exact) begin
          if (q !== e.v) begin
            fails++;
            $display("FAIL step_q: got %h want %h", q, e.v);
          end
        end else if (q === 8'h00 || q === 8'h01) begin
          fails++;
          $display("FAIL lfsr_period: got %h want not 00/01", q);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic cyc_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] v, input bit exact);
    exp_t e;
    e.v = v;
    e.exact = exact;
    sb.push_back(e);
  endtask

  task automatic do_load(input logic [7:0] v);
    din = v;
    load = 1'b1;
    cyc_n(1);
    load = 1'b0;
    cyc_n(1);
  endtask

  task automatic press;
    btn = 1'b1;
    cyc_n(DB + 8);
    btn = 1'b0;
    cyc_n(DB + 8);
  endtask

  initial begin
    int t0;
    int e0;

    // 1: reset state, then reset in the middle of a debounce
    #7;
    chk("rst_q", q, 8'h01);
    chk("rst_tick", tick, 1'b0);
    cyc_n(2);
    rst = 1'b0;
    cyc_n(2);
    do_load(8'h5A);
    chk("load_5a", q, 8'h5A);
    btn = 1'b1;
    cyc_n(10);
    btn = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_q", q, 8'h01);
    chk("midrst_num1", num1, 4'h0);
    chk("midrst_num0", num0, 4'h1);
    chk("midrst_tick", tick, 1'b0);
    cyc_n(2);
    rst = 1'b0;
    t0 = tick_cnt;
    cyc_n(40);
    chk("midrst_nostep", tick_cnt - t0, 0);
    chk("midrst_hold", q, 8'h01);

    // 2: LFSR from 01 with clean presses
    mode = 2'b00;
    push(8'h80, 1); push(8'h40, 1); push(8'h20, 1);
    push(8'h10, 1); push(8'h88, 1); push(8'hC4, 1);
    repeat (6) press();
    chk("press_q", q, 8'hC4);

    // 3: bouncing button then held, one step at edge 3+DB
    t0 = tick_cnt;
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      cyc_n(3);
    end
    push(8'hE2, 1);
    btn = 1'b1;
    e0 = cyc;
    cyc_n(25);
    btn = 1'b0;
    cyc_n(25);
    chk("bounce_steps", tick_cnt - t0, 1);
    chk("bounce_lat", tick_cyc[$], e0 + 3 + DB);

    // 4: shift modes on a loaded value
    do_load(8'h96);
    mode = 2'b01;
    push(8'h2C, 1);
    press();
    do_load(8'h96);
    mode = 2'b10;
    push(8'hCB, 1);
    press();
    do_load(8'h96);
    mode = 2'b11;
    push(8'h4B, 1);
    press();
    mode = 2'b00;

    // 5: zero-lock escape, and load held against auto ticks
    do_load(8'h00);
    chk("load_00", q, 8'h00);
    push(8'h01, 1);
    press();
    chk("zero_escape", q, 8'h01);
    din = 8'h5A;
    load = 1'b1;
    auto_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc_n(1);
      chk("ldhold_q", q, 8'h5A);
      chk("ldhold_tick", tick, 1'b0);
    end
    load = 1'b0;
    auto_en = 1'b0;
    cyc_n(2);

    // 6: auto-run steps, freeze, divider clear
    do_load(8'h01);
    push(8'h80, 1); push(8'h40, 1); push(8'h20, 1); push(8'h10, 1);
    t0 = tick_cnt;
    auto_en = 1'b1;
    e0 = cyc;
    cyc_n(17);
    auto_en = 1'b0;
    cyc_n(10);
    chk("auto_steps", tick_cnt - t0, 4);
    for (int k = 0; k < 4; k++)
      chk("auto_tick_cyc", tick_cyc[tick_cyc.size() - 4 + k],
          e0 + 4 * (k + 1));
    chk("auto_frozen", q, 8'h10);
    push(8'h88, 1);
    auto_en = 1'b1;
    e0 = cyc;
    cyc_n(6);
    auto_en = 1'b0;
    cyc_n(4);
    chk("div_cleared", tick_cyc[$], e0 + 4);
    chk("after_clear", q, 8'h88);

    // LFSR period: 255 auto steps back to 01, never 00 on the way
    do_load(8'h01);
    for (int k = 0; k < 254; k++) push(8'h00, 0);
    push(8'h01, 1);
    auto_en = 1'b1;
    cyc_n(255 * AD + 1);
    auto_en = 1'b0;
    cyc_n(5);
    chk("period_q", q, 8'h01);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
